// File: rtl/foo_sink.sv
`default_nettype none
// ============================================================================
// Module   : foo_sink
// Purpose  : Harness block beside Foo. Drives Foo's inputs (x = armed flag,
//            z = free-running timestamp while armed) and watches Foo's
//            outputs. Any output that differs from its value in the previous
//            cycle (or from the declared default right after reset) is
//            logged, while armed, as a timestamped record in a small FIFO
//            that is drained over a valid/ready stream.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            arm, disarm         - FSM control pulses (disarm wins)
//            clear               - flush FIFO and clear overflow
//            x, z                - drive Foo.x / Foo.z
//            y, undriven_output0,
//            undriven_output1    - observed Foo outputs
//            ev_valid, ev_ready,
//            ev_data             - event stream {tag,mask,y,u0,u1}
//            overflow            - sticky: an event was dropped
// Revision : 1.0 - initial release
// ============================================================================
module foo_sink #(
    parameter int DEPTH      = 4,
    parameter int Y_DEFAULT  = 3,
    parameter int U0_DEFAULT = 0,
    parameter int U1_DEFAULT = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic        disarm,
    input  logic        clear,
    output logic        x,
    output logic [2:0]  z,
    input  logic [1:0]  y,
    input  logic [3:0]  undriven_output0,
    input  logic [4:0]  undriven_output1,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [16:0] ev_data,
    output logic        overflow
);

    localparam int          c_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          c_CW     = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(DEPTH);
    localparam logic [1:0]  c_Y_DEF  = 2'(Y_DEFAULT);
    localparam logic [3:0]  c_U0_DEF = 4'(U0_DEFAULT);
    localparam logic [4:0]  c_U1_DEF = 5'(U1_DEFAULT);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_x;
    logic [2:0]        r_z;
    logic [1:0]        r_py;
    logic [3:0]        r_pu0;
    logic [4:0]        r_pu1;

    logic [16:0]       r_mem [DEPTH];
    logic [c_AW-1:0]   r_rd;
    logic [c_AW-1:0]   r_wr;
    logic [c_CW-1:0]   r_cnt;
    logic              r_ovf;

    logic [2:0]        w_mask;
    logic              w_event;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic [16:0]       w_rec;

    // Change detection against the previous-cycle shadows; mask[2] is y.
    assign w_mask  = {(y != r_py), (undriven_output0 != r_pu0), (undriven_output1 != r_pu1)};
    assign w_event = (r_state == ARMED) && (w_mask != 3'b000);
    assign w_rec   = {r_z, w_mask, y, undriven_output0, undriven_output1};

    assign w_full  = (r_cnt == c_FULL_CNT);
    assign w_pop   = ev_valid && ev_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign w_push  = w_event && (!w_full || w_pop);

    // FSM, timestamp and shadow registers. Shadows load every cycle so an
    // arm never sees a stale comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_x     <= 1'b0;
            r_z     <= 3'd0;
            r_py    <= c_Y_DEF;
            r_pu0   <= c_U0_DEF;
            r_pu1   <= c_U1_DEF;
        end else begin
            r_py  <= y;
            r_pu0 <= undriven_output0;
            r_pu1 <= undriven_output1;
            if (r_state == ARMED) begin
                r_z <= r_z + 3'd1;
            end
            case (r_state)
                IDLE: begin
                    if (arm && !disarm) begin
                        r_state <= ARMED;
                        r_x     <= 1'b1;
                    end
                end
                ARMED: begin
                    if (disarm) begin
                        r_state <= IDLE;
                        r_x     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_x     <= 1'b0;
                end
            endcase
        end
    end

    // Event FIFO. clear overrides every other FIFO action, including a
    // same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_rec;
                r_wr        <= r_wr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_CW'(1);
                2'b01:   r_cnt <= r_cnt - c_CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (w_event && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign x        = r_x;
    assign z        = r_z;
    assign ev_valid = (r_cnt != '0);
    // Head entry comes straight from storage; zero when nothing is queued.
    assign ev_data  = ev_valid ? r_mem[r_rd] : 17'd0;
    assign overflow = r_ovf;

endmodule
`default_nettype wire
